// File: rtl/ahfp_floor_divide_pow2_pipe.sv
// Two-stage IEEE-754 single-precision floor(x / 2^SHIFT) unit with valid/ready handshake.
// Stage 1 holds the decoded operand; stage 2 holds the finished result.
module ahfp_floor_divide_pow2_pipe #(
    parameter int SHIFT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data
);

    localparam logic signed [9:0] SHIFT_S = 10'(SHIFT);

    typedef enum logic [1:0] {
        CLS_NORM = 2'd0,
        CLS_ZERO = 2'd1,
        CLS_SPEC = 2'd2
    } cls_t;

    logic        vld_p1;
    logic        sgn_p1;
    logic [7:0]  exp_p1;
    logic [22:0] frac_p1;
    logic        mode_p1;
    cls_t        cls_p1;

    logic        adv_p2;
    logic [31:0] res_p1;

    // Exact scaling: a quotient that would need a denormal collapses to signed zero.
    function automatic logic [31:0] exact_div(input logic s, input logic [7:0] e,
                                              input logic [22:0] f);
        logic signed [9:0] ep;
        ep = $signed({2'b00, e}) - SHIFT_S;
        if (ep <= 10'sd0)
            return {s, 31'b0};
        return {s, ep[7:0], f};
    endfunction

    function automatic logic [31:0] floor_div(input logic s, input logic [7:0] e,
                                              input logic [22:0] f);
        logic signed [9:0] ev;
        logic signed [9:0] u;
        logic [7:0]        ep8;
        logic [23:0]       lsb;
        logic [22:0]       keep;
        logic              lost;
        logic [23:0]       fsum;
        ev   = $signed({2'b00, e});
        u    = ev - 10'sd127 - SHIFT_S;
        ep8  = e - 8'(SHIFT);
        if (u < 10'sd0)
            return s ? 32'hBF80_0000 : 32'h0000_0000;
        if (u >= 10'sd23)
            return {s, ep8, f};
        // lsb marks the units place of the quotient inside the 24-bit significand
        lsb  = 24'd1 << (5'd23 - u[4:0]);
        keep = ~(lsb[22:0] - 23'd1);
        lost = |(f & ~keep);
        // A carry out of the fraction field means the significand reached 2.0
        fsum = {1'b0, f & keep} + ((s && lost) ? lsb : 24'd0);
        return {s, ep8 + {7'b0, fsum[23]}, fsum[22:0]};
    endfunction

    assign adv_p2   = !out_valid || out_ready;
    assign in_ready = !vld_p1 || adv_p2;

    always_comb begin
        res_p1 = {sgn_p1, 31'b0};
        case (cls_p1)
            CLS_SPEC: res_p1 = {sgn_p1, exp_p1, frac_p1};
            CLS_ZERO: res_p1 = {sgn_p1, 31'b0};
            default:  res_p1 = mode_p1 ? exact_div(sgn_p1, exp_p1, frac_p1)
                                       : floor_div(sgn_p1, exp_p1, frac_p1);
        endcase
    end

    // Stage 1: decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_p1 <= 1'b0;
        else if (in_ready)
            vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            sgn_p1  <= in_data[31];
            exp_p1  <= in_data[30:23];
            frac_p1 <= in_data[22:0];
            mode_p1 <= in_mode;
            if (in_data[30:23] == 8'hFF)
                cls_p1 <= CLS_SPEC;
            else if (in_data[30:23] == 8'h00)
                cls_p1 <= CLS_ZERO;
            else
                cls_p1 <= CLS_NORM;
        end
    end

    // Stage 2: output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= 32'h0;
        end else if (adv_p2) begin
            out_valid <= vld_p1;
            if (vld_p1)
                out_data <= res_p1;
        end
    end

endmodule
